// File: rtl/fifo_tx_drain_if.sv
// FIFO read side plus serial-link and status signals of the drain.
// slave: the drain itself; master: whatever surrounds it.
interface fifo_tx_drain_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              tx_en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_pop;
    logic              tx_line;
    logic              tx_busy;
    logic              frame_done;
    logic [CNT_W-1:0]  frame_cnt;

    modport slave (
        input  tx_en, fifo_empty, fifo_data,
        output fifo_pop, tx_line, tx_busy, frame_done, frame_cnt
    );

    modport master (
        output tx_en, fifo_empty, fifo_data,
        input  fifo_pop, tx_line, tx_busy, frame_done, frame_cnt
    );
endinterface

// File: rtl/fifo_tx_drain.sv
// Pops FIFO words and sends them LSB-first as start/data/[parity]/stop frames.
// Optional even parity bit: define FIFO_TX_DRAIN_PARITY_EN. Frame = 1 + (DATA_W+2)*CLKS_PER_BIT cycles.
module fifo_tx_drain #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic           clk,
    input  logic           reset,
    fifo_tx_drain_if.slave bus
);
    localparam int CLK_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CLK_CW-1:0] CLK_LAST = CLK_CW'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_START,
        S_DATA,
`ifdef FIFO_TX_DRAIN_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [CLK_CW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [BIT_CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
`ifdef FIFO_TX_DRAIN_PARITY_EN
    logic               par_q, par_d;
`endif

    logic pop;
    logic line;
    logic done;
    logic bit_end;
    logic start_ok;

    assign bit_end  = (clk_cnt_q == CLK_LAST);
    assign start_ok = bus.tx_en && !bus.fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_cnt_q <= '0;
`ifdef FIFO_TX_DRAIN_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef FIFO_TX_DRAIN_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        frame_cnt_d = frame_cnt_q;
`ifdef FIFO_TX_DRAIN_PARITY_EN
        par_d       = par_q;
`endif
        pop  = 1'b0;
        line = 1'b1;
        done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_POP;
            end
            S_POP: begin
                pop       = 1'b1;
                shreg_d   = bus.fifo_data;
`ifdef FIFO_TX_DRAIN_PARITY_EN
                // Latched here because the shift register is consumed during DATA.
                par_d     = ^bus.fifo_data;
`endif
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = S_START;
            end
            S_START: begin
                line = 1'b0;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_CW'(1);
                end
            end
            S_DATA: begin
                line = shreg_q[0];
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shreg_d   = shreg_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef FIFO_TX_DRAIN_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_CW'(1);
                end
            end
`ifdef FIFO_TX_DRAIN_PARITY_EN
            S_PARITY: begin
                line = par_q;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = S_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_CW'(1);
                end
            end
`endif
            S_STOP: begin
                line = 1'b1;
                if (bit_end) begin
                    done        = 1'b1;
                    clk_cnt_d   = '0;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = start_ok ? S_POP : S_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.fifo_pop   = pop;
    assign bus.tx_line    = line;
    assign bus.tx_busy    = (state_q != S_IDLE);
    assign bus.frame_done = done;
    assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: doc/fifo_tx_drain.md
Name: fifo_tx_drain

Overview:
- Consumer on the read side of the team's 4-bit push/pop FIFO.
- Pops one word whenever the FIFO is non-empty and transmission is enabled.
- Sends the word LSB-first on a single serial line framed as: start bit (0), data bits, optional parity, stop bit (1).
- Sits between the FIFO and the off-block serial link; it is the drain for data written by the FIFO's producer.

Parameters:
- DATA_W, 4: width of the FIFO word and number of serial data bits.
- CLKS_PER_BIT, 4: clk cycles each serial bit is held. Must be ≥ 1.
- CNT_W, 8: width of the completed-frame counter.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_en  input  1  permits starting new frames; sampled only in IDLE and at end of STOP.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_W  FIFO read data; valid combinationally in the cycle fifo_pop=1.
- fifo_pop  output  1  one-cycle pop strobe to the FIFO.
- tx_line  output  1  serial output; idles high.
- tx_busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse on the last cycle of STOP.
- frame_cnt  output  CNT_W  count of completed frames; wraps.

Behaviour:
- **Reset (synchronous, active-high).**
  - State=IDLE, tx_line=1, fifo_pop=0, tx_busy=0, frame_done=0, frame_cnt=0, shift register=0, bit and clock counters=0.
  - Reset asserted mid-frame aborts the frame at the next edge. tx_line returns high and no frame_done is issued.
- **States:** IDLE, POP, START, DATA, [PARITY], STOP.
- **IDLE:** tx_line=1. If tx_en=1 and fifo_empty=0, go to POP; otherwise stay.
- **POP (exactly 1 cycle):**
  - fifo_pop=1.
  - Shift register loads fifo_data at the end of this cycle.
  - Next state is START.
  - fifo_pop is a decoded Moore output of POP; it is never high in any other state.
- **START:** tx_line=0 for CLKS_PER_BIT cycles, then DATA.
- **DATA:**
  - tx_line=shreg[0] for CLKS_PER_BIT cycles per bit; the shift register shifts right after each bit.
  - After DATA_W bits, go to PARITY if compiled in, else STOP.
- **STOP:**
  - tx_line=1 for CLKS_PER_BIT cycles.
  - On the last cycle: frame_done=1 and frame_cnt increments (2^CNT_W−1 wraps to 0).
  - Then go to POP if tx_en=1 and fifo_empty=0 (back-to-back, no idle gap); else go to IDLE.
- **Clock-per-bit counter:** counts 0..CLKS_PER_BIT−1. With CLKS_PER_BIT=1, each bit lasts exactly one cycle.
- **Latency:** from IDLE with the condition true at edge N:
  - fifo_pop is high in cycle N+1.
  - Start bit begins at cycle N+2.
- **Frame length:** 1 + (DATA_W+2)*CLKS_PER_BIT cycles including POP; 25 cycles at defaults.
- **tx_en deasserted mid-frame:** the current frame completes normally; no further pop.
- **fifo_empty rising during a frame:** no effect on the current frame.
- **fifo_empty deasserting while in START/DATA/STOP:** ignored until the STOP decision.
- **fifo_data outside POP:** ignored (the FIFO drives 0 when pop is low).
- **No retry, no error detection on the FIFO side:** popping while the FIFO is empty is impossible by construction.

Optional Feature:
- Macro: FIFO_TX_DRAIN_PARITY_EN.
- **Defined:**
  - PARITY state follows DATA.
  - tx_line = XOR of the DATA_W data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame length grows by CLKS_PER_BIT (29 cycles at defaults).
- **Undefined:** PARITY state and its logic are absent; DATA goes directly to STOP.

Test Plan:
- **Reset idle:** reset held 3 cycles, then tx_en=1, fifo_empty=1 for 20 cycles -> tx_line=1, fifo_pop=0, tx_busy=0, frame_cnt=0 throughout.
- **Single frame:** fifo_empty=0 for one pop, fifo_data=4'hA, tx_en=1 -> one fifo_pop pulse; tx_line shows 0,0,1,0,1,1, each held 4 cycles; frame_done pulse at the 25th cycle; frame_cnt=1.
- **Back-to-back:** FIFO supplies 4'h3 then 4'hC with fifo_empty=0 across both -> second fifo_pop occurs the cycle after the first frame_done, with no idle-high gap beyond the stop bit; frame_cnt=2.
- **tx_en drop:** tx_en falls during the DATA bit 1 of 4'h5, FIFO still non-empty -> frame completes (0,1,0,1,0,1), then IDLE with no further fifo_pop.
- **Reset mid-frame:** reset pulsed during bit 2 of 4'hF -> next edge tx_line=1, tx_busy=0, frame_cnt=0, no frame_done.
- **Parity (macro defined):** fifo_data=4'h7 -> parity bit 1 held 4 cycles before stop; frame_done at cycle 29. With 4'h3 -> parity bit 0.
